// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between an in-order
// pipeline and a word-wide data memory with combinational read.
// Sub-word stores are read-modify-write; SW writes directly.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          RISC-V width/sign encoding
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores/errors)
//   resp_err            misaligned or illegal funct3
//   mem_addr            word-aligned memory address (0 when idle)
//   mem_wdata, mem_we   memory write word / enable (WRITE state only)
//   mem_rdata           combinational read of word at mem_addr
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_we, r_err;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_word;

  logic        w_accept, w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merged;

  assign w_accept = req_valid && (r_state == IDLE);

  // Illegal encodings and misalignment are resolved at accept time so the
  // FSM can skip the memory entirely for errors.
  always_comb begin
    w_err = 1'b1;
    case (req_funct3)
      3'b000:  w_err = 1'b0;
      3'b001:  w_err = req_addr[0];
      3'b010:  w_err = (req_addr[1:0] != 2'b00);
      3'b100:  w_err = req_we;
      3'b101:  w_err = req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_err)                        w_next = RESP;
        else if (!req_we)                 w_next = READ;
        else if (req_funct3[1:0] == 2'b10) w_next = WRITE;
        else                              w_next = READ;
      end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_err   <= w_err;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == READ) r_word <= mem_rdata;
    end
  end

  // Little-endian lane selection from the captured word.
  always_comb begin
    w_byte = r_word[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = r_word[7:0];
      2'd1: w_byte = r_word[15:8];
      2'd2: w_byte = r_word[23:16];
      2'd3: w_byte = r_word[31:24];
      default: w_byte = r_word[7:0];
    endcase
    w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];
  end

  always_comb begin
    w_load = r_word;
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = r_word;
    endcase
  end

  // Merge store data into the old word; SW bypasses the merge.
  always_comb begin
    w_merged = r_word;
    case (r_f3[1:0])
      2'b00: case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = r_word;
      endcase
      2'b01: if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
             else           w_merged[15:0]  = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  // All outputs decode from state, so the asynchronous reset forces them
  // to their idle values immediately (including dropping mem_we).
  always_comb begin
    req_ready  = (r_state == IDLE);
    mem_we     = (r_state == WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = (r_state == RESP);
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (r_state == READ || r_state == WRITE)
      mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    if (r_state == WRITE) mem_wdata = w_merged;
    if (r_state == RESP) begin
      resp_err = r_err;
      if (!r_err && !r_we) resp_rdata = w_load;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: 16 words, commits on posedge while mem_we; tb preload port.
  logic [31:0] mem [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_idx = '0;
  logic [31:0] tb_data = '0;
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[5:2]] <= mem_wdata;
    else if (tb_we) mem[tb_idx] <= tb_data;
  end
  assign mem_rdata = mem[mem_addr[5:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   total = 0, passed = 0;
  int   we_cnt = 0, we_cyc = 0, last_acc = 0;
  int   viol_idle = 0, viol_align = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        last_acc = cyc;
      end
      if (mem_we) begin
        we_cnt++;
        we_cyc = cyc;
        if (mem_addr[1:0] != 2'b00) viol_align++;
      end
      if (!resp_valid && (resp_rdata != 0 || resp_err)) viol_idle++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int a;
          e = sb.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("resp_latency", cyc - a, e.lat);
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_idx = idx[3:0]; tb_data = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
  endtask

  // Waits for the handshake edge; returns the accept cycle number.
  task automatic wait_accept(output int acyc);
    int n;
    n = 0;
    acyc = -1;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready) begin acyc = cyc; break; end
      n++;
    end
    if (acyc < 0) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    int ac;
    exp_t e;
    e.rdata = er; e.err = ee; e.lat = el;
    we_cnt = 0;
    @(posedge clk); #1;
    sb.push_back(e);
    drive(we, f3, a, wd);
    wait_accept(ac);
    req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int a0, a1, n;
    exp_t e;
    // Reset state.
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    preload(0, 32'h87654321);
    preload(2, 32'h00000000);

    // Loads with sign/zero extension.
    issue(1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFF87, 1'b0, 2);
    issue(1'b0, 3'b100, 32'h3, 32'h0, 32'h00000087, 1'b0, 2);
    issue(1'b0, 3'b101, 32'h2, 32'h0, 32'h00008765, 1'b0, 2);
    issue(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF8765, 1'b0, 2);
    issue(1'b0, 3'b000, 32'h0, 32'h0, 32'h00000021, 1'b0, 2);
    issue(1'b0, 3'b001, 32'h0, 32'h0, 32'h00004321, 1'b0, 2);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h87654321, 1'b0, 2);

    // SB read-modify-write.
    issue(1'b1, 3'b000, 32'h1, 32'h123456AA, 32'h0, 1'b0, 3);
    chk("sb_word", mem[0], 32'h8765AA21);
    chk("sb_we_cnt", we_cnt, 32'd1);
    chk("sb_we_cycle", we_cyc - last_acc, 32'd2);

    // SW direct write, then read back.
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_word", mem[2], 32'hDEADBEEF);
    chk("sw_we_cnt", we_cnt, 32'd1);
    chk("sw_we_cycle", we_cyc - last_acc, 32'd1);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // SH upper half.
    issue(1'b1, 3'b001, 32'h2, 32'h0000BEEF, 32'h0, 1'b0, 3);
    chk("sh_word", mem[0], 32'hBEEFAA21);

    // Errors: misaligned and illegal encodings; memory must not change.
    issue(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b1, 1);
    chk("err_lh_we", we_cnt, 32'd0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    chk("err_f3_we", we_cnt, 32'd0);
    issue(1'b1, 3'b010, 32'h2, 32'h11111111, 32'h0, 1'b1, 1);
    chk("err_sw_we", we_cnt, 32'd0);
    issue(1'b1, 3'b100, 32'h0, 32'h22222222, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b010, 32'h1, 32'h0, 32'h0, 1'b1, 1);
    chk("err_mem_unchanged", mem[0], 32'hBEEFAA21);

    // Reset in the middle of the WRITE cycle of an SH.
    @(posedge clk); #1;
    drive(1'b1, 3'b001, 32'h2, 32'h00005555);
    wait_accept(a0);
    req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin @(posedge clk); #1; n++; end
    chk("rstw_saw_we", {31'h0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_we_drop", {31'h0, mem_we}, 32'd0);
    chk("rstw_ready", {31'h0, req_ready}, 32'd1);
    acc_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_word", mem[0], 32'hBEEFAA21);
    chk("rstw_ready_after", {31'h0, req_ready}, 32'd1);

    // Back-to-back loads with req_valid held.
    @(posedge clk); #1;
    e.rdata = 32'hBEEFAA21; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    e.rdata = 32'h000000EF; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    wait_accept(a0);
    drive(1'b0, 3'b100, 32'h8, 32'h0);
    wait_accept(a1);
    req_valid = 1'b0;
    wait_drain();
    chk("b2b_gap", a1 - a0, 32'd3);

    chk("idle_zero", viol_idle, 32'd0);
    chk("mem_addr_align", viol_align, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
